// File: rtl/axi_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// axi_pkg: burst/FSM types and next-address helper for axi_sram_slave.
// Optional macro AXI_SRAM_WRAP_EN enables WRAP bursts.        Rev 1.0
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } axi_wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } axi_rd_state_t;

  // Reserved burst type 2'b11 falls through to the INCR result.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [1:0]  burst,
                                                input logic [7:0]  len);
    logic [31:0] incr;
`ifdef AXI_SRAM_WRAP_EN
    logic [31:0] mask;
`else
    logic        unused_len;
`endif
    incr = addr + 32'd4;
    if (burst == FIXED) return addr;
`ifdef AXI_SRAM_WRAP_EN
    // (len+1)*4-1 collapses to {len, 2'b11} for the legal wrap lengths.
    mask = {22'd0, len, 2'b11};
    if (burst == WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (addr & ~mask) | (incr & mask);
`else
    unused_len = ^len;
`endif
    return incr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_slave_if.sv
`default_nettype none
// ============================================================================
// axi_interface: AXI4 subset used by axi_sram_slave, master/slave modports.
// Rev 1.0
// ============================================================================
interface axi_interface;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awaddr, awlen, awburst, awsize, awvalid, wdata, wstrb, wlast, wvalid,
           bready, araddr, arlen, arburst, arsize, arvalid, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awaddr, awlen, awburst, awsize, awvalid, wdata, wstrb, wlast, wvalid,
           bready, araddr, arlen, arburst, arsize, arvalid, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/axi_sram_slave_sram_1r1w.sv
`default_nettype none
// ============================================================================
// sram_1r1w: 32-bit 1R1W SRAM, byte-enabled write, registered read (read-first).
// Rev 1.0
// ============================================================================
module sram_1r1w #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= 32'd0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// axi_sram_slave: AXI4 burst responder over a 1R1W SRAM, independent R/W FSMs.
// Optional macro AXI_SRAM_WRAP_EN enables WRAP bursts.        Rev 1.0
// ============================================================================
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  axi_interface.slave  axi_bus
);

  axi_wr_state_t r_wr_state, w_wr_next;
  axi_rd_state_t r_rd_state, w_rd_next;

  logic [31:0] r_wr_addr, r_rd_addr;
  logic [1:0]  r_wr_burst, r_rd_burst;
  logic [7:0]  r_wr_len, r_rd_len, r_wr_beats, r_rd_beats;
  logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rd_en;
  logic [31:0] w_rd_data;
  logic        unused_inputs;

  assign unused_inputs = ^{axi_bus.awsize, axi_bus.arsize, axi_bus.wlast};

  assign w_aw_hs = axi_bus.awvalid && r_awready;
  assign w_w_hs  = axi_bus.wvalid  && r_wready;
  assign w_b_hs  = r_bvalid        && axi_bus.bready;
  assign w_ar_hs = axi_bus.arvalid && r_arready;
  assign w_r_hs  = r_rvalid        && axi_bus.rready;

  // Under backpressure no read is issued, so the output register holds rdata.
  assign w_rd_en = (r_rd_state == R_FETCH) || (w_r_hs && r_rd_beats != 8'd0);

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
      W_DATA:  if (w_w_hs && r_wr_beats == 8'd0) w_wr_next = W_RESP;
      W_RESP:  if (w_b_hs) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_next = R_FETCH;
      R_FETCH: w_rd_next = R_DATA;
      R_DATA:  if (w_r_hs && r_rd_beats == 8'd0) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Readies/valids are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_rd_state <= w_rd_next;
      r_awready  <= (w_wr_next == W_IDLE);
      r_wready   <= (w_wr_next == W_DATA);
      r_bvalid   <= (w_wr_next == W_RESP);
      r_arready  <= (w_rd_next == R_IDLE);
      r_rvalid   <= (w_rd_next == R_DATA);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_addr  <= 32'd0;
      r_wr_burst <= 2'd0;
      r_wr_len   <= 8'd0;
      r_wr_beats <= 8'd0;
    end else if (w_aw_hs) begin
      r_wr_addr  <= axi_bus.awaddr;
      r_wr_burst <= axi_bus.awburst;
      r_wr_len   <= axi_bus.awlen;
      r_wr_beats <= axi_bus.awlen;
    end else if (w_w_hs) begin
      r_wr_addr  <= axi_next_addr(r_wr_addr, r_wr_burst, r_wr_len);
      r_wr_beats <= r_wr_beats - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr  <= 32'd0;
      r_rd_burst <= 2'd0;
      r_rd_len   <= 8'd0;
      r_rd_beats <= 8'd0;
    end else if (w_ar_hs) begin
      r_rd_addr  <= axi_bus.araddr;
      r_rd_burst <= axi_bus.arburst;
      r_rd_len   <= axi_bus.arlen;
      r_rd_beats <= axi_bus.arlen;
    end else if (w_rd_en) begin
      r_rd_addr <= axi_next_addr(r_rd_addr, r_rd_burst, r_rd_len);
      if (r_rd_state == R_DATA) r_rd_beats <= r_rd_beats - 8'd1;
    end
  end

  sram_1r1w #(
    .ADDR_W (MEM_WORDS_LOG2)
  ) u_sram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_w_hs),
    .wr_addr (r_wr_addr[MEM_WORDS_LOG2+1:2]),
    .wr_data (axi_bus.wdata),
    .wr_strb (axi_bus.wstrb),
    .rd_en   (w_rd_en),
    .rd_addr (r_rd_addr[MEM_WORDS_LOG2+1:2]),
    .rd_data (w_rd_data)
  );

  assign axi_bus.awready = r_awready;
  assign axi_bus.wready  = r_wready;
  assign axi_bus.bvalid  = r_bvalid;
  assign axi_bus.arready = r_arready;
  assign axi_bus.rvalid  = r_rvalid;
  assign axi_bus.rdata   = w_rd_data;

endmodule
`default_nettype wire
